// File: rtl/cmsdk_apb_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmsdk_apb_initiator_pkg
// Purpose  : Shared definitions for the APB3 initiator: FSM state encodings
//            and the value driven on PWDATA during read transfers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cmsdk_apb_initiator_pkg;

    // Transfer sequencing states (2-bit encoding).
    typedef enum logic [1:0] {
        ARM_APBI_IDLE   = 2'd0,
        ARM_APBI_SETUP  = 2'd1,
        ARM_APBI_ACCESS = 2'd2,
        ARM_APBI_RESP   = 2'd3
    } apbi_state_t;

    // PWDATA carries this value for reads so no stale write data leaks out.
    localparam logic [31:0] ARM_APBI_RDFILL = 32'h0000_0000;

endpackage : cmsdk_apb_initiator_pkg
`default_nettype wire

// File: rtl/cmsdk_apb_initiator_tmo.sv
`default_nettype none
// ============================================================================
// Module   : cmsdk_apb_initiator_tmo
// Purpose  : Saturating ACCESS-phase wait counter. Cleared on entry to
//            ACCESS, counts cycles with PREADY low and flags expiry once
//            TIMEOUT wait cycles have elapsed. TIMEOUT = 0 disables expiry.
// Ports    : clk     - clock
//            rst_n   - asynchronous active-low reset
//            clear   - reset the count to zero
//            inc     - count one wait cycle (saturating)
//            expired - count has reached TIMEOUT (never set if TIMEOUT = 0)
// Revision : 1.0 - initial release
// ============================================================================
module cmsdk_apb_initiator_tmo #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit EN = (TIMEOUT != 0);
    // With expiry disabled the counter simply saturates at all-ones.
    localparam logic [CW-1:0] LIMIT = EN ? CW'(TIMEOUT) : {CW{1'b1}};

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = EN && (count == LIMIT);

endmodule : cmsdk_apb_initiator_tmo
`default_nettype wire

// File: rtl/cmsdk_apb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : cmsdk_apb_initiator
// Purpose  : APB3 initiator. Accepts one read/write command at a time on a
//            valid/ready port, runs the APB SETUP and ACCESS phases and
//            returns read data plus error/timeout status on a valid/ready
//            response port. All APB outputs are registered.
// Ports    : PCLK, PRESETn            - clock, async active-low reset
//            cmd_valid/ready          - command handshake
//            cmd_write/addr/wdata     - command payload (addr is a byte addr)
//            rsp_valid/ready          - response handshake
//            rsp_rdata/err/timeout    - response payload
//            PSEL/PENABLE/PADDR/PWRITE/PWDATA - APB request (word address)
//            PRDATA/PREADY/PSLVERR    - APB completion
// Revision : 1.0 - initial release
// ============================================================================
module cmsdk_apb_initiator
    import cmsdk_apb_initiator_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [ADDR_W-3:0] PADDR,
    output logic              PWRITE,
    output logic [31:0]       PWDATA,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apbi_state_t       state;
    apbi_state_t       state_nxt;

    logic              psel_nxt;
    logic              penable_nxt;
    logic [ADDR_W-3:0] paddr_nxt;
    logic              pwrite_nxt;
    logic [31:0]       pwdata_nxt;
    logic              rsp_valid_nxt;
    logic [31:0]       rsp_rdata_nxt;
    logic              rsp_err_nxt;
    logic              rsp_timeout_nxt;

    logic              tmo_clear;
    logic              tmo_inc;
    logic              tmo_expired;

    // Byte-lane bits of the address are not carried on PADDR.
    logic              unused_addr_lsb;
    assign unused_addr_lsb = ^cmd_addr[1:0];

    // Ready is a pure decode of the state register, so cmd_valid never
    // combinationally reaches cmd_ready.
    assign cmd_ready = (state == ARM_APBI_IDLE);

    // The wait count restarts on the SETUP->ACCESS edge and counts each
    // ACCESS cycle the slave holds PREADY low.
    assign tmo_clear = (state == ARM_APBI_SETUP);
    assign tmo_inc   = (state == ARM_APBI_ACCESS) && !PREADY;

    cmsdk_apb_initiator_tmo #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .clear   (tmo_clear),
        .inc     (tmo_inc),
        .expired (tmo_expired)
    );

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Every output is registered below,
    // so this block only computes the values to load at the next edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt       = state;
        psel_nxt        = PSEL;
        penable_nxt     = PENABLE;
        paddr_nxt       = PADDR;
        pwrite_nxt      = PWRITE;
        pwdata_nxt      = PWDATA;
        rsp_valid_nxt   = rsp_valid;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_err_nxt     = rsp_err;
        rsp_timeout_nxt = rsp_timeout;

        unique case (state)
            ARM_APBI_IDLE: begin
                if (cmd_valid) begin
                    psel_nxt    = 1'b1;
                    penable_nxt = 1'b0;
                    paddr_nxt   = cmd_addr[ADDR_W-1:2];
                    pwrite_nxt  = cmd_write;
                    pwdata_nxt  = cmd_write ? cmd_wdata : ARM_APBI_RDFILL;
                    state_nxt   = ARM_APBI_SETUP;
                end
            end

            ARM_APBI_SETUP: begin
                penable_nxt = 1'b1;
                state_nxt   = ARM_APBI_ACCESS;
            end

            ARM_APBI_ACCESS: begin
                // PREADY takes priority over an expiry on the same edge.
                if (PREADY) begin
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_rdata_nxt   = PWRITE ? 32'h0 : PRDATA;
                    rsp_err_nxt     = PSLVERR;
                    rsp_timeout_nxt = 1'b0;
                    state_nxt       = ARM_APBI_RESP;
                end else if (tmo_expired) begin
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_rdata_nxt   = 32'h0;
                    rsp_err_nxt     = 1'b1;
                    rsp_timeout_nxt = 1'b1;
                    state_nxt       = ARM_APBI_RESP;
                end
            end

            ARM_APBI_RESP: begin
                // Payload is held untouched until the consumer takes it.
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = ARM_APBI_IDLE;
                end
            end

            default: begin
                state_nxt = ARM_APBI_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers.
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= ARM_APBI_IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= 32'h0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'h0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            PSEL        <= psel_nxt;
            PENABLE     <= penable_nxt;
            PADDR       <= paddr_nxt;
            PWRITE      <= pwrite_nxt;
            PWDATA      <= pwdata_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_timeout <= rsp_timeout_nxt;
        end
    end

endmodule : cmsdk_apb_initiator
`default_nettype wire

// File: tb/tb_cmsdk_apb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmsdk_apb_initiator
// Purpose  : Directed self-checking bench for the APB3 initiator with
//            ADDR_W = 12 and TIMEOUT = 16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmsdk_apb_initiator;

    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 16;

    logic              PCLK;
    logic              PRESETn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              PSEL;
    logic              PENABLE;
    logic [ADDR_W-3:0] PADDR;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    int n_tests = 0;
    int n_fail  = 0;

    cmsdk_apb_initiator #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PADDR       (PADDR),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 ns after it.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Present a command and let it be accepted on the next edge.
    task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wd);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        chk("cmd_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("cmd_ready_back", cmd_ready, 1);
    endtask

    logic [31:0] held_rdata;

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        PRDATA    = 32'h0;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_psel",    PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite",  PWRITE, 0);
        chk("rst_paddr",   32'(PADDR), 0);
        chk("rst_pwdata",  PWDATA, 0);
        chk("rst_rvalid",  rsp_valid, 0);
        chk("rst_rdata",   rsp_rdata, 0);
        chk("rst_err",     rsp_err, 0);
        chk("rst_tmo",     rsp_timeout, 0);
        PRESETn = 1'b1;
        tick();

        // ---------------- write 0xC00, zero wait ----------------
        issue(1'b1, 12'hC00, 32'h1ACCE551);            // edge N
        chk("wr_n_psel",    PSEL, 1);
        chk("wr_n_penable", PENABLE, 0);
        chk("wr_n_paddr",   32'(PADDR), 32'h300);
        chk("wr_n_pwrite",  PWRITE, 1);
        chk("wr_n_pwdata",  PWDATA, 32'h1ACCE551);
        chk("wr_n_ready",   cmd_ready, 0);
        tick();                                         // edge N+1
        chk("wr_n1_psel",    PSEL, 1);
        chk("wr_n1_penable", PENABLE, 1);
        chk("wr_n1_pwdata",  PWDATA, 32'h1ACCE551);
        chk("wr_n1_rvalid",  rsp_valid, 0);
        tick();                                         // edge N+2
        chk("wr_n2_psel",    PSEL, 0);
        chk("wr_n2_penable", PENABLE, 0);
        chk("wr_n2_rvalid",  rsp_valid, 1);
        chk("wr_n2_err",     rsp_err, 0);
        chk("wr_n2_tmo",     rsp_timeout, 0);
        chk("wr_n2_rdata",   rsp_rdata, 0);
        handshake();

        // ---------------- read 0xFE0, 3 wait states ----------------
        PREADY = 1'b0;
        PRDATA = 32'hFFFF_0000;
        issue(1'b0, 12'hFE0, 32'hAAAA_5555);            // edge N
        chk("rd_paddr",  32'(PADDR), 32'h3F8);
        chk("rd_pwrite", PWRITE, 0);
        chk("rd_pwdata", PWDATA, 0);
        tick();                                         // edge N+1
        chk("rd_penable", PENABLE, 1);
        for (int i = 0; i < 3; i++) begin               // edges N+2..N+4
            tick();
            chk("rd_wait_psel",   PSEL, 1);
            chk("rd_wait_pen",    PENABLE, 1);
            chk("rd_wait_rvalid", rsp_valid, 0);
        end
        PREADY = 1'b1;
        PRDATA = 32'h0000_0024;
        tick();                                         // edge N+5
        PRDATA = 32'h0;
        chk("rd_rvalid", rsp_valid, 1);
        chk("rd_rdata",  rsp_rdata, 32'h24);
        chk("rd_err",    rsp_err, 0);
        chk("rd_psel",   PSEL, 0);
        handshake();

        // ---------------- read with PSLVERR ----------------
        PSLVERR = 1'b1;
        PRDATA  = 32'hDEAD_BEEF;
        issue(1'b0, 12'h010, 32'h0);
        tick();
        tick();
        PSLVERR = 1'b0;
        PRDATA  = 32'h0;
        chk("slverr_rvalid", rsp_valid, 1);
        chk("slverr_err",    rsp_err, 1);
        chk("slverr_tmo",    rsp_timeout, 0);
        chk("slverr_rdata",  rsp_rdata, 32'hDEADBEEF);
        handshake();

        // ---------------- timeout: PREADY held low ----------------
        PREADY = 1'b0;
        PRDATA = 32'h1234_5678;
        issue(1'b0, 12'h020, 32'h0);                    // edge N
        tick();                                         // edge N+1
        for (int i = 0; i < TIMEOUT; i++) begin         // 16 wait edges
            tick();
            chk("tmo_wait_psel",   PSEL, 1);
            chk("tmo_wait_rvalid", rsp_valid, 0);
        end
        tick();                                         // abort edge
        chk("tmo_psel",    PSEL, 0);
        chk("tmo_penable", PENABLE, 0);
        chk("tmo_rvalid",  rsp_valid, 1);
        chk("tmo_err",     rsp_err, 1);
        chk("tmo_flag",    rsp_timeout, 1);
        chk("tmo_rdata",   rsp_rdata, 0);
        handshake();

        // ---------------- PREADY on the abort edge wins ----------------
        PREADY = 1'b0;
        PRDATA = 32'h0000_00A5;
        issue(1'b0, 12'h024, 32'h0);
        tick();
        for (int i = 0; i < TIMEOUT; i++) tick();
        PREADY = 1'b1;
        tick();
        chk("edge_rvalid", rsp_valid, 1);
        chk("edge_err",    rsp_err, 0);
        chk("edge_tmo",    rsp_timeout, 0);
        chk("edge_rdata",  rsp_rdata, 32'hA5);
        handshake();

        // ---------------- response back-pressure ----------------
        PREADY = 1'b1;
        PRDATA = 32'h0BAD_F00D;
        issue(1'b0, 12'h040, 32'h0);
        cmd_valid = 1'b1;                               // next command waits
        cmd_write = 1'b1;
        cmd_addr  = 12'h080;
        cmd_wdata = 32'hCAFE_0001;
        tick();
        tick();
        PRDATA = 32'h0;
        chk("bp_rvalid", rsp_valid, 1);
        held_rdata = rsp_rdata;
        chk("bp_rdata", held_rdata, 32'h0BADF00D);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_rvalid_hold", rsp_valid, 1);
            chk("bp_rdata_hold", rsp_rdata, 32'h0BADF00D);
            chk("bp_psel", PSEL, 0);
        end
        rsp_ready = 1'b1;
        tick();                                         // handshake edge
        rsp_ready = 1'b0;
        chk("bp_hs_rvalid", rsp_valid, 0);
        chk("bp_hs_psel",   PSEL, 0);
        tick();                                         // next command accepted
        cmd_valid = 1'b0;
        chk("bp_next_psel",  PSEL, 1);
        chk("bp_next_paddr", 32'(PADDR), 32'h020);
        chk("bp_next_pwdata", PWDATA, 32'hCAFE0001);
        tick();
        tick();
        chk("bp_next_rvalid", rsp_valid, 1);
        chk("bp_next_rdata",  rsp_rdata, 0);
        handshake();

        // ---------------- reset during ACCESS ----------------
        PREADY = 1'b0;
        issue(1'b1, 12'h100, 32'h5555_AAAA);
        tick();                                         // now in ACCESS
        chk("rstm_pre_pen", PENABLE, 1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("rstm_psel",    PSEL, 0);
        chk("rstm_penable", PENABLE, 0);
        chk("rstm_pwdata",  PWDATA, 0);
        chk("rstm_rvalid",  rsp_valid, 0);
        PREADY = 1'b1;
        tick();
        PRESETn = 1'b1;
        tick();
        tick();
        chk("rstm_after_rvalid", rsp_valid, 0);
        chk("rstm_after_psel",   PSEL, 0);
        chk("rstm_after_ready",  cmd_ready, 1);

        // Recovery: a normal write still completes.
        issue(1'b1, 12'h104, 32'h0000_0007);
        chk("rec_psel", PSEL, 1);
        tick();
        tick();
        chk("rec_rvalid", rsp_valid, 1);
        chk("rec_err",    rsp_err, 0);
        handshake();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cmsdk_apb_initiator
`default_nettype wire
